// File: rtl/preco_calc.sv
// preco_calc: weight x unit-price multiply, rounded divide by SCALE, saturating output; 2-clock latency.
module preco_calc #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SCALE = 1000,
    parameter int ROUND = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  weight_kg,
    input  logic [IN_W-1:0]  price_per_kg,
    output logic [OUT_W-1:0] total_price,
    output logic             out_valid,
    output logic             overflow
);
    localparam int PW = 2 * IN_W;
    localparam int QW = PW + 1;
    localparam logic [QW-1:0] BIAS = QW'(ROUND != 0 ? SCALE / 2 : 0);
    localparam logic [QW-1:0] DIV  = QW'(SCALE);
    localparam logic [QW-1:0] MAX  = QW'({OUT_W{1'b1}});

    logic [PW-1:0] prod;
    logic          v1;
    logic [QW-1:0] q;
    logic          sat;

    // One extra bit so the rounding bias can never wrap the product.
    always_comb begin
        q   = ({1'b0, prod} + BIAS) / DIV;
        sat = q > MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod        <= '0;
            v1          <= 1'b0;
            out_valid   <= 1'b0;
            total_price <= '0;
            overflow    <= 1'b0;
        end else begin
            if (in_valid) prod <= PW'(weight_kg) * PW'(price_per_kg);
            v1        <= in_valid;
            out_valid <= v1;
            if (v1) begin
                total_price <= sat ? MAX[OUT_W-1:0] : q[OUT_W-1:0];
                overflow    <= sat;
            end
        end
    end
endmodule

// File: tb/tb_preco_calc.sv
// tb_preco_calc: randomized and directed checks of preco_calc against an arithmetic price model.
module tb_preco_calc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] w = '0, p = '0;
    logic [15:0] tp, tp0;
    logic        ov, ov0, vo, vo0;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] hold_t = '0, hold_t0 = '0;
    logic        hold_o = 1'b0, hold_o0 = 1'b0;
    logic [15:0] qw[$], qp[$];
    bit          qv[$];

    always #5 clk = ~clk;

    preco_calc #(.ROUND(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .weight_kg(w), .price_per_kg(p),
        .total_price(tp), .out_valid(vo), .overflow(ov)
    );
    preco_calc #(.ROUND(0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .weight_kg(w), .price_per_kg(p),
        .total_price(tp0), .out_valid(vo0), .overflow(ov0)
    );

    // Price in cents from grams x cents/kg, optional half-up rounding, clamped to 16 bits.
    function automatic logic [16:0] model(input longint wt, input longint pr, input bit rnd);
        longint q;
        q = (wt * pr + (rnd ? 500 : 0)) / 1000;
        return q > 65535 ? {1'b1, 16'hFFFF} : {1'b0, 16'(q)};
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (vo !== 1'b0 || tp !== 16'd0 || ov !== 1'b0 || vo0 !== 1'b0 || tp0 !== 16'd0 || ov0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got v=%b tp=%0d ov=%b v0=%b tp0=%0d ov0=%b, want all 0", vo, tp, ov, vo0, tp0, ov0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (vo !== 1'b0 || vo0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got v=%b v0=%b, want 0", vo, vo0);
        end
    endtask

    task automatic test_directed;
        logic [15:0] tw[8]  = '{600, 1, 1, 65535, 1000, 1001, 0, 2500};
        logic [15:0] tpr[8] = '{700, 500, 499, 65535, 65535, 65535, 1234, 399};
        logic [15:0] er[8]  = '{420, 1, 0, 65535, 65535, 65535, 0, 998};
        logic [15:0] et[8]  = '{420, 0, 0, 65535, 65535, 65535, 0, 997};
        bit          eo[8]  = '{0, 0, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; w = tw[i]; p = tpr[i];
            @(negedge clk);
            in_valid = 1'b0; w = 16'($urandom); p = 16'($urandom);
            n_cmp++;
            if (vo !== 1'b0) begin
                n_bad++;
                $display("FAIL latency[%0d]: out_valid=%b after 1 clock, want 0", i, vo);
            end
            @(negedge clk);
            n_cmp++;
            if (vo !== 1'b1 || tp !== er[i] || ov !== eo[i] || vo0 !== 1'b1 || tp0 !== et[i] || ov0 !== eo[i]) begin
                n_bad++;
                $display("FAIL directed[%0d] (%0d,%0d): got v=%b tp=%0d ov=%b tp0=%0d ov0=%b, want v=1 tp=%0d ov=%b tp0=%0d ov0=%b",
                         i, tw[i], tpr[i], vo, tp, ov, tp0, ov0, er[i], eo[i], et[i], eo[i]);
            end
            hold_t = er[i]; hold_o = eo[i]; hold_t0 = et[i]; hold_o0 = eo[i];
        end
        @(negedge clk);
    endtask

    // Drives the queued inputs one per clock and checks every cycle against the model, including holds.
    task automatic run_stream(input string tag);
        int n = qw.size();
        logic [16:0] e, e0;
        bit ev;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            ev = (i >= 2) && qv[i-2];
            if (ev) begin
                e  = model(qw[i-2], qp[i-2], 1'b1);
                e0 = model(qw[i-2], qp[i-2], 1'b0);
                hold_t = e[15:0]; hold_o = e[16]; hold_t0 = e0[15:0]; hold_o0 = e0[16];
            end
            n_cmp++;
            if (vo !== ev || tp !== hold_t || ov !== hold_o || vo0 !== ev || tp0 !== hold_t0 || ov0 !== hold_o0) begin
                n_bad++;
                $display("FAIL %s[%0d]: got v=%b tp=%0d ov=%b v0=%b tp0=%0d ov0=%b, want v=%b tp=%0d ov=%b tp0=%0d ov0=%b",
                         tag, i, vo, tp, ov, vo0, tp0, ov0, ev, hold_t, hold_o, hold_t0, hold_o0);
            end
            if (i < n) begin
                in_valid = qv[i]; w = qw[i]; p = qp[i];
            end else begin
                in_valid = 1'b0; w = 16'($urandom); p = 16'($urandom);
            end
        end
        qw.delete(); qp.delete(); qv.delete();
    endtask

    task automatic test_back_to_back;
        qw = '{600, 0, 2500}; qp = '{700, 1234, 399}; qv = '{1, 1, 1};
        run_stream("back_to_back");
        n_cmp++;
        if (tp !== 16'd998) begin
            n_bad++;
            $display("FAIL b2b_last: total_price=%0d, want 998", tp);
        end
    endtask

    task automatic test_idle_hold;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0; w = 16'($urandom); p = 16'($urandom);
            n_cmp++;
            if (vo !== 1'b0 || tp !== hold_t || ov !== hold_o || vo0 !== 1'b0 || tp0 !== hold_t0) begin
                n_bad++;
                $display("FAIL idle_hold[%0d]: got v=%b tp=%0d ov=%b tp0=%0d, want v=0 tp=%0d ov=%b tp0=%0d",
                         i, vo, tp, ov, tp0, hold_t, hold_o, hold_t0);
            end
        end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        in_valid = 1'b1; w = 16'd600; p = 16'd700;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (vo !== 1'b0 || tp !== 16'd0 || ov !== 1'b0 || tp0 !== 16'd0 || ov0 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got v=%b tp=%0d ov=%b tp0=%0d ov0=%b, want all 0", vo, tp, ov, tp0, ov0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_t = '0; hold_o = 1'b0; hold_t0 = '0; hold_o0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (vo !== 1'b0 || vo0 !== 1'b0 || tp !== 16'd0 || tp0 !== 16'd0) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: got v=%b v0=%b tp=%0d tp0=%0d, want 0", i, vo, vo0, tp, tp0);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            qv.push_back($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin qw.push_back(16'($urandom)); qp.push_back(16'($urandom)); end
                1: begin qw.push_back(16'($urandom_range(0, 3000))); qp.push_back(16'($urandom_range(0, 2000))); end
                2: begin qw.push_back(16'($urandom_range(990, 1010))); qp.push_back(16'($urandom_range(64000, 65535))); end
                default: begin qw.push_back(16'($urandom_range(0, 3))); qp.push_back(16'($urandom_range(495, 505))); end
            endcase
        end
        run_stream("random");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_idle_hold;
        test_mid_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
